// File: rtl/si_inst_fetch_if.sv
// Fetch-stage bus bundle: the instruction-memory request/response channel,
// the decode-side valid/ready channel, and the redirect input from execute.
interface si_inst_fetch_if #(
    parameter int INST_DW = 32,
    parameter int INST_AW = 32
);
    logic               imem_req_o;
    logic [INST_AW-1:0] imem_addr_o;
    logic               imem_gnt_i;
    logic               imem_rvalid_i;
    logic [INST_DW-1:0] imem_rdata_i;
    logic               redirect_en_i;
    logic [INST_AW-1:0] redirect_pc_i;
    logic               inst_valid_o;
    logic               inst_ready_i;
    logic [INST_DW-1:0] inst_o;
    logic [INST_AW-1:0] inst_pc_o;

    // Fetch stage side.
    modport master (
        output imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        input  redirect_en_i, redirect_pc_i, inst_ready_i
    );

    // Memory / decode / execute side.
    modport slave (
        input  imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        output redirect_en_i, redirect_pc_i, inst_ready_i
    );
endinterface

// File: rtl/si_inst_fetch.sv
// Instruction fetch: owns the PC, keeps at most one imem read in flight and
// holds one fetched instruction for decode. Redirects from execute flush the
// held instruction and cause exactly one stale response to be dropped.
//
// state  | meaning
// S_IDLE | no request; waiting for the output slot to free up
// S_REQ  | request to imem at pc, held until granted
// S_WAIT | granted; waiting for rvalid of the fetch at fetch_pc
module si_inst_fetch #(
    parameter int                 INST_DW  = 32,
    parameter int                 INST_AW  = 32,
    parameter logic [INST_AW-1:0] RESET_PC = '0
) (
    input logic             clk,
    input logic             rst,
    si_inst_fetch_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t             state;
    logic [INST_AW-1:0] pc;
    logic [INST_AW-1:0] fetch_pc;
    logic [INST_AW-1:0] redir_pc;
    logic               drop;
    logic               redir_pend;
    logic               inst_valid;
    logic [INST_DW-1:0] inst;
    logic [INST_AW-1:0] inst_pc;

    logic [INST_AW-1:0] target;
    logic               slot_free;
    logic               req;
    logic               xfer;
    logic               unused_lsbs;

    assign target      = {bus.redirect_pc_i[INST_AW-1:2], 2'b00};
    assign unused_lsbs = ^bus.redirect_pc_i[1:0];
    assign slot_free   = !inst_valid || bus.inst_ready_i;

    // The request is masked while decode holds an unconsumed instruction, so
    // a grant can only happen when the response is guaranteed a free slot.
    // Once raised in S_REQ it stays up until granted: the slot can only
    // drain, never refill, while no fetch is outstanding.
    assign req  = (state == S_REQ) && slot_free;
    assign xfer = req && bus.imem_gnt_i;

    assign bus.imem_req_o   = req;
    assign bus.imem_addr_o  = pc;
    assign bus.inst_valid_o = inst_valid;
    assign bus.inst_o       = inst;
    assign bus.inst_pc_o    = inst_pc;

    // Fetch FSM, PC and output register; redirect takes priority everywhere.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            fetch_pc   <= RESET_PC;
            redir_pc   <= RESET_PC;
            drop       <= 1'b0;
            redir_pend <= 1'b0;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
        end else begin
            if (bus.inst_ready_i) begin
                inst_valid <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (bus.redirect_en_i) begin
                        pc    <= target;
                        state <= S_REQ;
                    end else if (slot_free) begin
                        state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.redirect_en_i) begin
                        if (xfer) begin
                            state      <= S_WAIT;
                            fetch_pc   <= pc;
                            pc         <= target;
                            drop       <= 1'b1;
                            redir_pend <= 1'b0;
                        end else if (req) begin
                            // Request already on the bus: let it finish at
                            // the old address and drop its response.
                            redir_pend <= 1'b1;
                            drop       <= 1'b1;
                            redir_pc   <= target;
                        end else begin
                            pc <= target;
                        end
                    end else if (xfer) begin
                        state    <= S_WAIT;
                        fetch_pc <= pc;
                        if (redir_pend) begin
                            pc         <= redir_pc;
                            redir_pend <= 1'b0;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.redirect_en_i) begin
                        pc <= target;
                        if (bus.imem_rvalid_i) begin
                            drop  <= 1'b0;
                            state <= S_REQ;
                        end else begin
                            drop <= 1'b1;
                        end
                    end else if (bus.imem_rvalid_i) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= S_REQ;
                        end else begin
                            inst       <= bus.imem_rdata_i;
                            inst_pc    <= fetch_pc;
                            inst_valid <= 1'b1;
                            pc         <= fetch_pc + INST_AW'(4);
                            state      <= slot_free ? S_REQ : S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (bus.redirect_en_i) begin
                inst_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_si_inst_fetch.sv
// Directed bench for si_inst_fetch with a small imem responder whose grant
// and response delays are set per step; data word is derived from address.
module tb_si_inst_fetch;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   gnt_dly;
    int   rv_dly;

    si_inst_fetch_if bus ();

    si_inst_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return {16'hC0DE, a[15:0]};
    endfunction

    // imem responder: decides gnt/rvalid for the current cycle at the negedge.
    initial begin : imem_model
        int          g_wait;
        int          rsp_cnt;
        logic [31:0] rsp_addr;
        g_wait            = 0;
        rsp_cnt           = 0;
        rsp_addr          = '0;
        bus.imem_gnt_i    = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            bus.imem_gnt_i    = 1'b0;
            bus.imem_rvalid_i = 1'b0;
            bus.imem_rdata_i  = 32'hDEAD_BEEF;
            if (rsp_cnt != 0) begin
                rsp_cnt = rsp_cnt - 1;
                if (rsp_cnt == 0) begin
                    bus.imem_rvalid_i = 1'b1;
                    bus.imem_rdata_i  = mem_word(rsp_addr);
                end
            end
            if (bus.imem_req_o && rsp_cnt == 0) begin
                if (g_wait >= gnt_dly) begin
                    bus.imem_gnt_i = 1'b1;
                    g_wait         = 0;
                    rsp_cnt        = rv_dly;
                    rsp_addr       = bus.imem_addr_o;
                end else begin
                    g_wait = g_wait + 1;
                end
            end else if (!bus.imem_req_o) begin
                g_wait = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp)
        else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 3 time units after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #3;
    endtask

    task automatic chk_out(input string tag, input logic req, input logic [31:0] addr,
                           input logic vld);
        chk({tag, " req"}, {31'b0, bus.imem_req_o}, {31'b0, req});
        if (req) chk({tag, " addr"}, bus.imem_addr_o, addr);
        chk({tag, " valid"}, {31'b0, bus.inst_valid_o}, {31'b0, vld});
    endtask

    task automatic chk_inst(input string tag, input logic [31:0] pc, input logic [31:0] ins);
        chk({tag, " valid"}, {31'b0, bus.inst_valid_o}, 32'd1);
        chk({tag, " pc"}, bus.inst_pc_o, pc);
        chk({tag, " inst"}, bus.inst_o, ins);
    endtask

    initial begin
        n_cmp             = 0;
        n_err             = 0;
        gnt_dly           = 0;
        rv_dly            = 1;
        rst               = 1'b1;
        bus.inst_ready_i  = 1'b1;
        bus.redirect_en_i = 1'b0;
        bus.redirect_pc_i = '0;

        // Reset state
        cyc();
        cyc();
        chk("rst req", {31'b0, bus.imem_req_o}, 32'd0);
        chk("rst addr", bus.imem_addr_o, 32'h0);
        chk("rst valid", {31'b0, bus.inst_valid_o}, 32'd0);
        chk("rst inst", bus.inst_o, 32'h0);
        chk("rst pc", bus.inst_pc_o, 32'h0);
        rst = 1'b0;                                   // C0

        // Zero-wait memory, decode always ready
        cyc(); chk_out("c1", 1'b1, 32'h0, 1'b0);      // C1
        cyc(); chk_out("c2", 1'b0, 32'h0, 1'b0);      // C2
        cyc(); chk_inst("c3", 32'h0, 32'h0050_0093);  // C3
        chk_out("c3", 1'b1, 32'h4, 1'b1);
        cyc(); chk_out("c4", 1'b0, 32'h0, 1'b0);      // C4
        cyc(); chk_inst("c5", 32'h4, 32'hC0DE_0004);  // C5
        chk_out("c5", 1'b1, 32'h8, 1'b1);

        // Decode stall with inst at PC 4
        bus.inst_ready_i = 1'b0;
        #1;
        chk("stall req", {31'b0, bus.imem_req_o}, 32'd0);
        for (int i = 0; i < 5; i++) begin             // C6..C10
            cyc();
            chk_inst("stall", 32'h4, 32'hC0DE_0004);
            chk("stall req", {31'b0, bus.imem_req_o}, 32'd0);
        end
        bus.inst_ready_i = 1'b1;
        #1;
        chk_out("rise", 1'b1, 32'h8, 1'b1);
        cyc(); chk_out("c11", 1'b0, 32'h0, 1'b0);     // C11
        cyc(); chk_inst("c12", 32'h8, 32'hC0DE_0008); // C12
        chk_out("c12", 1'b1, 32'hC, 1'b1);
        cyc();                                        // C13
        gnt_dly = 3;
        rv_dly  = 4;

        // Slow grant and slow response at 0x10
        cyc(); chk_inst("c14", 32'hC, 32'hC0DE_000C); // C14
        chk_out("c14", 1'b1, 32'h10, 1'b1);
        for (int i = 0; i < 3; i++) begin             // C15..C17
            cyc();
            chk_out("gwait", 1'b1, 32'h10, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin             // C18..C21
            cyc();
            chk_out("rwait", 1'b0, 32'h0, 1'b0);
        end
        gnt_dly = 0;
        rv_dly  = 1;
        cyc(); chk_inst("c22", 32'h10, 32'hC0DE_0010); // C22
        chk_out("c22", 1'b1, 32'h14, 1'b1);
        cyc();                                        // C23
        cyc(); chk_inst("c24", 32'h14, 32'hC0DE_0014); // C24
        cyc();                                        // C25
        cyc(); chk_inst("c26", 32'h18, 32'hC0DE_0018); // C26
        cyc();                                        // C27
        rv_dly = 3;
        cyc(); chk_out("c28", 1'b1, 32'h20, 1'b1);    // C28

        // Redirect to 0x100 while waiting for 0x20
        cyc();                                        // C29
        bus.redirect_en_i = 1'b1;
        bus.redirect_pc_i = 32'h100;
        cyc();                                        // C30
        bus.redirect_en_i = 1'b0;
        chk_out("rd30", 1'b0, 32'h0, 1'b0);
        chk("rd30 addr", bus.imem_addr_o, 32'h100);
        cyc(); chk_out("rd31", 1'b0, 32'h0, 1'b0);    // C31
        cyc(); chk_out("rd32", 1'b1, 32'h100, 1'b0);  // C32
        rv_dly = 1;
        cyc(); chk_out("rd33", 1'b0, 32'h0, 1'b0);    // C33
        cyc(); chk_inst("rd34", 32'h100, 32'hC0DE_0100); // C34
        chk_out("rd34", 1'b1, 32'h104, 1'b1);

        // Redirect to 0x30 in the same cycle as the grant of 0x104
        bus.redirect_en_i = 1'b1;
        bus.redirect_pc_i = 32'h30;
        cyc();                                        // C35
        bus.redirect_en_i = 1'b0;
        chk_out("rg35", 1'b0, 32'h0, 1'b0);
        cyc(); chk_out("rg36", 1'b1, 32'h30, 1'b0);   // C36
        cyc();                                        // C37
        bus.inst_ready_i = 1'b0;

        // Redirect to 0x203 while inst at 0x30 is held
        cyc(); chk_inst("h38", 32'h30, 32'hC0DE_0030); // C38
        chk("h38 req", {31'b0, bus.imem_req_o}, 32'd0);
        bus.redirect_en_i = 1'b1;
        bus.redirect_pc_i = 32'h203;
        cyc();                                        // C39
        bus.redirect_en_i = 1'b0;
        chk_out("h39", 1'b1, 32'h200, 1'b0);
        cyc();                                        // C40
        cyc(); chk_inst("h41", 32'h200, 32'hC0DE_0200); // C41
        chk("h41 req", {31'b0, bus.imem_req_o}, 32'd0);
        rv_dly = 4;
        bus.inst_ready_i = 1'b1;
        #1;
        chk_out("h41r", 1'b1, 32'h204, 1'b1);

        // Async reset in the middle of S_WAIT, late response afterwards
        cyc(); chk_out("w42", 1'b0, 32'h0, 1'b0);     // C42
        cyc();                                        // C43
        rst = 1'b1;
        #1;
        chk("ar req", {31'b0, bus.imem_req_o}, 32'd0);
        chk("ar addr", bus.imem_addr_o, 32'h0);
        chk("ar valid", {31'b0, bus.inst_valid_o}, 32'd0);
        chk("ar inst", bus.inst_o, 32'h0);
        chk("ar pc", bus.inst_pc_o, 32'h0);
        cyc();                                        // C44
        rst    = 1'b0;
        rv_dly = 1;
        cyc(); chk_out("ar45", 1'b1, 32'h0, 1'b0);    // C45
        cyc(); chk_out("ar46", 1'b0, 32'h0, 1'b0);    // C46
        gnt_dly = 2;
        cyc(); chk_inst("ar47", 32'h0, 32'h0050_0093); // C47
        chk_out("ar47", 1'b1, 32'h4, 1'b1);

        // Two redirects while an ungranted request is on the bus
        bus.redirect_en_i = 1'b1;
        bus.redirect_pc_i = 32'h40;
        cyc();                                        // C48
        bus.redirect_pc_i = 32'h80;
        chk_out("p48", 1'b1, 32'h4, 1'b0);
        cyc();                                        // C49
        bus.redirect_en_i = 1'b0;
        chk_out("p49", 1'b1, 32'h4, 1'b0);
        cyc();                                        // C50
        chk_out("p50", 1'b0, 32'h0, 1'b0);
        chk("p50 addr", bus.imem_addr_o, 32'h80);
        gnt_dly = 0;
        cyc(); chk_out("p51", 1'b1, 32'h80, 1'b0);    // C51
        cyc(); chk_out("p52", 1'b0, 32'h0, 1'b0);     // C52
        cyc(); chk_inst("p53", 32'h80, 32'hC0DE_0080); // C53

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
